// File: rtl/cpu7_ifu_pkg.sv
// Shared IFU definitions: response FSM encoding, fetch exception codes and the
// default uncached address segment.
package cpu7_ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ifu_state_t;

  localparam logic [5:0] EXC_ADEF       = 6'h08;
  localparam logic [2:0] UC_SEG_DEFAULT = 3'b101;

endpackage

// File: rtl/cpu7_ifu_imem.sv
// Word selector: returns the addressed 32-bit word of a 128-bit instruction
// line using the shared line rotator.
module cpu7_ifu_imem_line_sel (
  input  logic [127:0] line,
  input  logic [1:0]   sel,
  output logic [31:0]  word
);

  logic [127:0] rotated;

  cpu7_ifu_imem_align u_align (
    .line    (line),
    .sel     (sel),
    .rotated (rotated)
  );

  logic [95:0] unused_upper;
  assign unused_upper = rotated[127:32];
  assign word         = rotated[31:0];

endmodule

// File: rtl/cpu7_ifu_imem_align.sv
// Rotates a 128-bit instruction line right by whole 32-bit words so the
// selected word lands in bits [31:0].
module cpu7_ifu_imem_align (
  input  logic [127:0] line,
  input  logic [1:0]   sel,
  output logic [127:0] rotated
);

  always_comb begin
    rotated = line;
    case (sel)
      2'd0: rotated = line;
      2'd1: rotated = {line[31:0], line[127:32]};
      2'd2: rotated = {line[63:0], line[127:64]};
      2'd3: rotated = {line[95:0], line[127:96]};
      default: rotated = line;
    endcase
  end

endmodule

// File: rtl/cpu7_ifu_imem_resp.sv
// Instruction-memory response stage: accepts fetches, drives the synchronous
// line RAM and returns one rotated line per request. Optional extra wait
// cycles are enabled with `define CPU7_IMEM_RESP_WAIT_EN.
module cpu7_ifu_imem_resp
  import cpu7_ifu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [2:0]  UC_SEG      = UC_SEG_DEFAULT
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inst_req,
  input  logic [31:0]  inst_addr,
  input  logic         inst_cancel,
  output logic         inst_addr_ok,
  output logic         inst_valid,
  output logic [127:0] inst_rdata,
  output logic [1:0]   inst_count,
  output logic         inst_ex,
  output logic [5:0]   inst_exccode,
  output logic         inst_uncache,
  output logic         ram_en,
  output logic [27:0]  ram_addr,
  input  logic [127:0] ram_rdata
);

  ifu_state_t   state, state_nxt;
  logic         accept;
  logic         wait_done;
  logic         load_out;
  logic [2:0]   seg_q;
  logic [1:0]   sel_q;
  logic         misal_q;
  logic [127:0] rot_line;
  logic [127:0] line_src;

  assign accept       = resetn & inst_req & ~inst_cancel &
                        ((state == ST_IDLE) | (state == ST_RESP));
  assign inst_addr_ok = accept;
  assign ram_en       = accept & (inst_addr[1:0] == 2'b00);
  assign ram_addr     = inst_addr[31:4];
  assign inst_valid   = (state == ST_RESP);
  assign load_out     = (state == ST_WAIT) & ~inst_cancel & wait_done;

  cpu7_ifu_imem_align u_align (
    .line    (ram_rdata),
    .sel     (sel_q),
    .rotated (rot_line)
  );

`ifdef CPU7_IMEM_RESP_WAIT_EN
  localparam int unsigned   CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt;
  logic [127:0]  hold_line;
  logic          first;

  // RAM data is only valid in the first WAIT cycle; later cycles use the copy.
  assign first     = (cnt == CNT_INIT);
  assign wait_done = (cnt == '0);
  assign line_src  = first ? rot_line : hold_line;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt       <= '0;
      hold_line <= '0;
    end else begin
      if (inst_cancel)
        cnt <= '0;
      else if (accept)
        cnt <= CNT_INIT;
      else if ((state == ST_WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;
      if ((state == ST_WAIT) && first)
        hold_line <= rot_line;
    end
  end
`else
  logic unused_wait_cycles;
  assign unused_wait_cycles = (WAIT_CYCLES != 0);
  assign wait_done          = 1'b1;
  assign line_src           = rot_line;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (inst_cancel)    state_nxt = ST_IDLE;
        else if (wait_done) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = accept ? ST_WAIT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_q   <= '0;
      sel_q   <= '0;
      misal_q <= 1'b0;
    end else if (accept) begin
      seg_q   <= inst_addr[31:29];
      sel_q   <= inst_addr[3:2];
      misal_q <= |inst_addr[1:0];
    end
  end

  // Response registers are loaded only for the RESP cycle and cleared otherwise.
  always_ff @(posedge clock) begin
    if (!resetn || !load_out) begin
      inst_rdata   <= '0;
      inst_count   <= '0;
      inst_ex      <= 1'b0;
      inst_exccode <= '0;
      inst_uncache <= 1'b0;
    end else begin
      inst_rdata   <= misal_q ? '0 : line_src;
      inst_count   <= 2'd3 - sel_q;
      inst_ex      <= misal_q;
      inst_exccode <= misal_q ? EXC_ADEF : '0;
      inst_uncache <= (seg_q == UC_SEG);
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_imem_resp.sv
// Self-checking bench for cpu7_ifu_imem_resp: directed steps plus a random
// phase, checked against a transaction-level timing/data model.
module tb_cpu7_ifu_imem_resp;

`ifdef CPU7_IMEM_RESP_WAIT_EN
  localparam int unsigned TB_WAIT = 3;
  localparam int          LAT     = 2 + TB_WAIT;
`else
  localparam int unsigned TB_WAIT = 2;
  localparam int          LAT     = 2;
`endif

  logic         clock = 1'b0;
  logic         resetn;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_cancel;
  logic         inst_addr_ok;
  logic         inst_valid;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic         inst_uncache;
  logic         ram_en;
  logic [27:0]  ram_addr;
  logic [127:0] ram_rdata;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int           due;
    logic [127:0] data;
    logic [1:0]   cnt;
    logic         ex;
    logic         uc;
  } exp_t;
  exp_t q[$];

  cpu7_ifu_imem_resp #(
    .WAIT_CYCLES (TB_WAIT),
    .UC_SEG      (3'b101)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_valid   (inst_valid),
    .inst_rdata   (inst_rdata),
    .inst_count   (inst_count),
    .inst_ex      (inst_ex),
    .inst_exccode (inst_exccode),
    .inst_uncache (inst_uncache),
    .ram_en       (ram_en),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [27:0] idx, input int k);
    logic [1:0] kk;
    kk = 2'(k);
    return {kk, idx, 2'b10};
  endfunction

  // RAM responder: garbage whenever no read was issued the previous cycle.
  always @(posedge clock) begin
    if (ram_en)
      ram_rdata <= {word_of(ram_addr, 3), word_of(ram_addr, 2),
                    word_of(ram_addr, 1), word_of(ram_addr, 0)};
    else
      ram_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic req, input logic [31:0] addr, input logic cancel,
                      input logic rstn, output logic acc);
    logic         busy, exp_ok, exp_ram, exp_v;
    exp_t         cur, e;
    exp_t         keep[$];
    logic [27:0]  idx;
    int           sel;
    inst_req    = req;
    inst_addr   = addr;
    inst_cancel = cancel;
    resetn      = rstn;
    @(negedge clock);
    busy  = 1'b0;
    exp_v = 1'b0;
    cur   = '{due: 0, data: '0, cnt: 2'd0, ex: 1'b0, uc: 1'b0};
    foreach (q[i]) begin
      if (q[i].due > cyc) busy = 1'b1;
      if (q[i].due == cyc) begin
        exp_v = 1'b1;
        cur   = q[i];
      end
    end
    exp_ok  = rstn & req & ~cancel & ~busy;
    exp_ram = exp_ok & (addr[1:0] == 2'b00);
    chk("addr_ok", 128'(inst_addr_ok), 128'(exp_ok));
    chk("ram_en", 128'(ram_en), 128'(exp_ram));
    if (exp_ram) chk("ram_addr", 128'(ram_addr), 128'(addr[31:4]));
    chk("valid", 128'(inst_valid), 128'(exp_v));
    chk("rdata", inst_rdata, cur.data);
    chk("count", 128'(inst_count), 128'(cur.cnt));
    chk("ex", 128'(inst_ex), 128'(cur.ex));
    chk("exccode", 128'(inst_exccode), cur.ex ? 128'(8'h08) : 128'(0));
    chk("uncache", 128'(inst_uncache), 128'(cur.uc));
    foreach (q[i])
      if (q[i].due > cyc && !cancel && rstn) keep.push_back(q[i]);
    q = keep;
    if (exp_ok) begin
      idx   = addr[31:4];
      sel   = int'(addr[3:2]);
      e.due = cyc + LAT;
      e.ex  = (addr[1:0] != 2'b00);
      e.cnt = 2'(3 - sel);
      e.uc  = (addr[31:29] == 3'b101);
      e.data = '0;
      if (!e.ex)
        for (int i = 0; i < 4; i++) e.data[32*i +: 32] = word_of(idx, (sel + i) % 4);
      q.push_back(e);
    end
    acc = exp_ok;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    logic        acc;
    logic [31:0] a;
    logic        rq, cn, rs;
    int          first_acc;
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    @(posedge clock);
    #1;
    // Reset held, even with a request present.
    step(1'b1, 32'h1C00_0000, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);
    // Aligned line fetch with word select 2.
    step(1'b1, 32'h1C00_0008, 1'b0, 1'b1, acc);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Uncached segment, word 0.
    step(1'b1, 32'hA000_0000, 1'b0, 1'b1, acc);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Misaligned address: exception, no RAM access.
    step(1'b1, 32'h1C00_0002, 1'b0, 1'b1, acc);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Back-to-back requests held high, address advances on each accept.
    a = 32'h1C00_0004;
    first_acc = -1;
    for (int i = 0; i < 4 * LAT; i++) begin
      step(1'b1, a, 1'b0, 1'b1, acc);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc - 1;
        a = a + 32'd4;
      end
    end
    chk("first_accept_immediate", 128'(first_acc), 128'(cyc - 4 * LAT));
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Cancel one cycle after accept, then re-request.
    step(1'b1, 32'h1C00_0010, 1'b0, 1'b1, acc);
    step(1'b1, 32'h1C00_0020, 1'b1, 1'b1, acc);
    step(1'b1, 32'h1C00_0020, 1'b0, 1'b1, acc);
    chk("accept_after_cancel", 128'(acc), 128'(1));
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Request with cancel in IDLE is ignored.
    step(1'b1, 32'h1C00_0030, 1'b1, 1'b1, acc);
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Cancel in RESP keeps the pulse but blocks a new accept.
    step(1'b1, 32'h1C00_0044, 1'b0, 1'b1, acc);
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b1, 32'h1C00_0050, 1'b1, 1'b1, acc);
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Reset while waiting discards the response.
    step(1'b1, 32'h1C00_0060, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      cn = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 39) != 0);
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      step(rq, a, cn, rs, acc);
    end
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
